// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock level FIFO: level width,
// threshold range check and the level -> flag mapping used by reset and next-state logic.
package sync_fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   // Level counts 0..DEPTH inclusive, so one bit wider than the address.
   function automatic int unsigned level_width(input int unsigned size_log2);
      return size_log2 + 1;
   endfunction

   function automatic bit thresh_ok(input int unsigned depth,
                                    input int unsigned afull,
                                    input int unsigned aempty);
      return (afull >= 1) && (afull <= depth) && (aempty <= depth - 1);
   endfunction

   function automatic fifo_flags_t compute_flags(input int unsigned level,
                                                 input int unsigned depth,
                                                 input int unsigned afull,
                                                 input int unsigned aempty);
      fifo_flags_t f;
      f.full         = (level == depth);
      f.empty        = (level == 0);
      f.almost_full  = (level >= afull);
      f.almost_empty = (level <= aempty);
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage with one write port and one registered read port.
// Storage is never reset; only the read data register is.
module sync_fifo_mem #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with registered flags, occupancy level and sticky error flags.
// Define SYNC_FIFO_LEVEL_SVA_EN to compile in embedded concurrent assertions.
module sync_fifo_level
   import sync_fifo_pkg::*;
#(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned SIZE_LOG2     = 5,
   parameter int unsigned AFULL_THRESH  = (2 ** SIZE_LOG2) - 2,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 p_write_en,
   input  logic [WIDTH-1:0]     p_write_data,
   output logic                 p_write_full,
   input  logic                 p_read_en,
   output logic [WIDTH-1:0]     p_read_data,
   output logic                 p_read_empty,
   output logic [SIZE_LOG2:0]   p_level,
   output logic                 p_almost_full,
   output logic                 p_almost_empty,
   output logic                 p_overflow,
   output logic                 p_underflow
);

   localparam int unsigned DEPTH = 2 ** SIZE_LOG2;
   localparam int unsigned LW    = level_width(SIZE_LOG2);
   localparam fifo_flags_t RST_FLAGS =
      compute_flags(0, DEPTH, AFULL_THRESH, AEMPTY_THRESH);

   logic [LW-1:0] wptr_q, wptr_d;
   logic [LW-1:0] rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d;
   fifo_flags_t   flags_q, flags_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          write_acc;
   logic          read_acc;

   // Acceptance uses the registered flags, so a full FIFO rejects a write
   // even when a read in the same cycle frees a slot.
   always_comb begin
      write_acc = p_write_en & ~flags_q.full;
      read_acc  = p_read_en & ~flags_q.empty;
      wptr_d    = wptr_q + LW'(write_acc);
      rptr_d    = rptr_q + LW'(read_acc);
      level_d   = level_q + LW'(write_acc) - LW'(read_acc);
      flags_d   = compute_flags(32'(level_d), DEPTH, AFULL_THRESH, AEMPTY_THRESH);
      ovf_d     = ovf_q | (p_write_en & flags_q.full);
      unf_d     = unf_q | (p_read_en & flags_q.empty);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         flags_q <= RST_FLAGS;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         flags_q <= flags_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   sync_fifo_mem #(
      .WIDTH (WIDTH),
      .AW    (SIZE_LOG2)
   ) u_mem (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (write_acc),
      .waddr_i (wptr_q[SIZE_LOG2-1:0]),
      .wdata_i (p_write_data),
      .re_i    (read_acc),
      .raddr_i (rptr_q[SIZE_LOG2-1:0]),
      .rdata_o (p_read_data)
   );

   assign p_write_full   = flags_q.full;
   assign p_read_empty   = flags_q.empty;
   assign p_almost_full  = flags_q.almost_full;
   assign p_almost_empty = flags_q.almost_empty;
   assign p_level        = level_q;
   assign p_overflow     = ovf_q;
   assign p_underflow    = unf_q;

`ifdef SYNC_FIFO_LEVEL_SVA_EN
   localparam bit THRESH_OK = thresh_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH);

   a_thresh_range: assert property (@(posedge clk) THRESH_OK);

   a_wptr_inc: assert property (@(posedge clk) disable iff (rst)
      write_acc |=> (wptr_q == $past(wptr_q) + LW'(1)));
   a_wptr_hold: assert property (@(posedge clk) disable iff (rst)
      !write_acc |=> $stable(wptr_q));
   a_rptr_inc: assert property (@(posedge clk) disable iff (rst)
      read_acc |=> (rptr_q == $past(rptr_q) + LW'(1)));
   a_rptr_hold: assert property (@(posedge clk) disable iff (rst)
      !read_acc |=> $stable(rptr_q));

   a_level_ptr: assert property (@(posedge clk) disable iff (rst)
      level_q == LW'(wptr_q - rptr_q));
   a_level_max: assert property (@(posedge clk) disable iff (rst)
      32'(level_q) <= DEPTH);

   a_flags: assert property (@(posedge clk) disable iff (rst)
      flags_q == compute_flags(32'(level_q), DEPTH, AFULL_THRESH, AEMPTY_THRESH));

   a_no_x: assert property (@(posedge clk) disable iff (rst)
      !$isunknown({p_write_full, p_read_empty, p_level, p_almost_full,
                   p_almost_empty, p_overflow, p_underflow, p_read_data}));
`endif

endmodule

// File: tb/tb_sync_fifo_level.sv
// Directed self-checking bench for sync_fifo_level (DEPTH=32, AFULL=30, AEMPTY=2).
module tb_sync_fifo_level;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       p_write_en = 1'b0;
   logic [7:0] p_write_data = '0;
   logic       p_write_full;
   logic       p_read_en = 1'b0;
   logic [7:0] p_read_data;
   logic       p_read_empty;
   logic [5:0] p_level;
   logic       p_almost_full;
   logic       p_almost_empty;
   logic       p_overflow;
   logic       p_underflow;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   sync_fifo_level #(
      .WIDTH         (8),
      .SIZE_LOG2     (5),
      .AFULL_THRESH  (30),
      .AEMPTY_THRESH (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .p_write_en     (p_write_en),
      .p_write_data   (p_write_data),
      .p_write_full   (p_write_full),
      .p_read_en      (p_read_en),
      .p_read_data    (p_read_data),
      .p_read_empty   (p_read_empty),
      .p_level        (p_level),
      .p_almost_full  (p_almost_full),
      .p_almost_empty (p_almost_empty),
      .p_overflow     (p_overflow),
      .p_underflow    (p_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_reset(input string tag);
      check({tag, " empty"},  32'(p_read_empty), 32'd1);
      check({tag, " full"},   32'(p_write_full), 32'd0);
      check({tag, " level"},  32'(p_level), 32'd0);
      check({tag, " aempty"}, 32'(p_almost_empty), 32'd1);
      check({tag, " afull"},  32'(p_almost_full), 32'd0);
      check({tag, " ovf"},    32'(p_overflow), 32'd0);
      check({tag, " unf"},    32'(p_underflow), 32'd0);
      check({tag, " rdata"},  32'(p_read_data), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] wval;
      logic [7:0] rval;

      repeat (3) tick();
      check_idle_reset("rst");
      rst = 1'b0;
      repeat (2) tick();
      check_idle_reset("idle");

      // Fill 0x00..0x1F
      for (int i = 0; i < 32; i++) begin
         p_write_en   = 1'b1;
         p_write_data = 8'(i);
         tick();
         check("fill level", 32'(p_level), 32'(i + 1));
         check("fill afull", 32'(p_almost_full), 32'(i + 1 >= 30));
         check("fill aempty", 32'(p_almost_empty), 32'(i + 1 <= 2));
         check("fill full", 32'(p_write_full), 32'(i + 1 == 32));
         check("fill empty", 32'(p_read_empty), 32'd0);
      end

      // Write while full
      p_write_data = 8'hAA;
      tick();
      p_write_en = 1'b0;
      check("ovf level", 32'(p_level), 32'd32);
      check("ovf flag", 32'(p_overflow), 32'd1);
      tick();
      check("ovf sticky", 32'(p_overflow), 32'd1);
      check("ovf full", 32'(p_write_full), 32'd1);

      // Drain in order
      for (int i = 0; i < 32; i++) begin
         p_read_en = 1'b1;
         tick();
         check("drain data", 32'(p_read_data), 32'(i));
         check("drain level", 32'(p_level), 32'(31 - i));
         check("drain empty", 32'(p_read_empty), 32'(i == 31));
         check("drain full", 32'(p_write_full), 32'd0);
      end

      // Read while empty
      tick();
      p_read_en = 1'b0;
      check("unf flag", 32'(p_underflow), 32'd1);
      check("unf rdata", 32'(p_read_data), 32'h1F);
      check("unf level", 32'(p_level), 32'd0);
      tick();
      check("unf sticky", 32'(p_underflow), 32'd1);
      check("unf rdata hold", 32'(p_read_data), 32'h1F);

      // Level 16 then simultaneous read+write across pointer wrap
      wval = 8'h40;
      rval = 8'h40;
      for (int i = 0; i < 16; i++) begin
         p_write_en   = 1'b1;
         p_write_data = wval;
         wval++;
         tick();
      end
      check("l16 level", 32'(p_level), 32'd16);
      p_read_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         p_write_data = wval;
         wval++;
         tick();
         check("rw level", 32'(p_level), 32'd16);
         check("rw data", 32'(p_read_data), 32'(rval));
         rval++;
      end
      p_write_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("to10 data", 32'(p_read_data), 32'(rval));
         rval++;
      end
      p_read_en = 1'b0;
      tick();
      check("l10 level", 32'(p_level), 32'd10);
      check("l10 ovf", 32'(p_overflow), 32'd1);
      check("l10 unf", 32'(p_underflow), 32'd1);

      // Asynchronous reset mid-burst
      p_write_en   = 1'b1;
      p_write_data = 8'h77;
      tick();
      #3;
      rst        = 1'b1;
      p_write_en = 1'b0;
      #1;
      check_idle_reset("async rst");
      tick();
      rst = 1'b0;
      tick();
      check_idle_reset("post rst");

      p_write_en   = 1'b1;
      p_write_data = 8'h5C;
      tick();
      p_write_en = 1'b0;
      check("5c level", 32'(p_level), 32'd1);
      check("5c empty", 32'(p_read_empty), 32'd0);
      p_read_en = 1'b1;
      tick();
      p_read_en = 1'b0;
      check("5c data", 32'(p_read_data), 32'h5C);
      check("5c empty after", 32'(p_read_empty), 32'd1);
      check("5c unf", 32'(p_underflow), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sync_fifo_level.md
# sync_fifo_level

Single-clock, parametrised FIFO with registered full/empty flags, an occupancy level output, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the single-clock sibling of the async FIFO, used wherever producer and consumer share a clock. It provides the level/occupancy behaviour the async FIFO does not expose.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- SIZE_LOG2, 5, log2 of depth; DEPTH = 2**SIZE_LOG2 (≥2)
- AFULL_THRESH, DEPTH-2, p_almost_full asserts when level ≥ this (1..DEPTH)
- AEMPTY_THRESH, 2, p_almost_empty asserts when level ≤ this (0..DEPTH-1)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- p_write_en  in  1  write request
- p_write_data  in  WIDTH  write word
- p_write_full  out  1  registered full flag
- p_read_en  in  1  read request
- p_read_data  out  WIDTH  registered read word
- p_read_empty  out  1  registered empty flag
- p_level  out  SIZE_LOG2+1  registered occupancy, 0..DEPTH
- p_almost_full  out  1  registered, level ≥ AFULL_THRESH
- p_almost_empty  out  1  registered, level ≤ AEMPTY_THRESH
- p_overflow  out  1  sticky: write attempted while full
- p_underflow  out  1  sticky: read attempted while empty

## Operation
- Pointers r_write_ptr_bin, r_read_ptr_bin: SIZE_LOG2+1 bits, wrap modulo 2**(SIZE_LOG2+1); low SIZE_LOG2 bits address memory.
- Write accepted = p_write_en && !p_write_full; word stored at write address, write pointer +1.
- Read accepted = p_read_en && !p_read_empty; word at read address loaded into p_read_data, read pointer +1.
- Rejected requests: no pointer, memory, level or data change.
- Level next = level + write_acc − read_acc; simultaneous accepted read and write leave level unchanged.
- Flags registered from next level: full = (level_next == DEPTH), empty = (level_next == 0), almost flags by threshold compare.
- Full with read+write: read accepted, write rejected (full is registered; no write-through). Empty with read+write: write accepted, read rejected, p_underflow set.
- p_overflow set on p_write_en && p_write_full; p_underflow set on p_read_en && p_read_empty; both held until rst.
- Invariant: p_level == r_write_ptr_bin − r_read_ptr_bin (mod 2**(SIZE_LOG2+1)), never > DEPTH.

## Timing
- Reset values: p_write_full 0, p_read_empty 1, p_level 0, p_almost_full 0, p_almost_empty 1 (AEMPTY_THRESH ≥ 0), p_read_data 0, p_overflow 0, p_underflow 0, pointers 0.
- rst asserts asynchronously mid-operation: all state returns to reset values immediately; memory contents not cleared and not readable until rewritten.
- Write-to-empty-deassert latency: 1 cycle (empty low the cycle after the accepted write).
- Read latency: p_read_data valid the cycle after the accepted read; holds value until next accepted read.
- Error flags assert the cycle after the offending request.
- All outputs change only on posedge clk or rst.

## Configuration
- SYNC_FIFO_LEVEL_SVA_EN: when defined, embedded concurrent assertions (disable iff rst) are compiled in: pointer +1 per accepted op, stable on rejected op, level invariant, level ≤ DEPTH, flag/level consistency, no X on outputs outside reset. When undefined, no assertions; RTL behaviour identical.

## Structure
- Package sync_fifo_pkg: level type width function, threshold range-check function, shared flag-compute function (level → full/empty/almost flags).
- Sub-module sync_fifo_mem: DEPTH×WIDTH register array, one write port, one registered read port; no reset on storage.

## Test plan (WIDTH=8, SIZE_LOG2=5, DEPTH=32, AFULL_THRESH=30, AEMPTY_THRESH=2)
- Reset then idle → empty=1, full=0, level=0, almost_empty=1, overflow=underflow=0.
- Write 0x00..0x1F back-to-back → level 1..32, almost_full at level 30, full the cycle after 32nd write; read back 32 words in order 0x00..0x1F, empty after last.
- Write when full (data 0xAA) → level stays 32, p_overflow=1 next cycle and stays; later reads never return 0xAA.
- Read when empty → p_underflow=1, pointers and p_read_data unchanged.
- Level 16, simultaneous read+write for 100 cycles (pointer wrap) → level constant 16, data order preserved across wrap.
- Level 10, assert rst mid-burst for 1 cycle → all outputs at reset values immediately, subsequent write/read of 0x5C returns 0x5C.
